// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the multicycle RISC-V control unit:
// state and ALUOp encodings, opcode/ALUControl/ImmSrc constants, per-state control word.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        aluop_e     aluop;
        logic       regwrite;
    } ctrl_t;

    // Moore control word for each state; unlisted fields stay zero.
    function automatic ctrl_t state_ctrl(input state_e s);
        ctrl_t c;
        c       = '0;
        c.aluop = ALUOP_ADD;
        case (s)
            S_FETCH: begin
                c.irwrite   = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
                c.pcupdate  = 1'b1;
            end
            S_DECODE: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            S_MEMADR: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            S_MEMREAD:  c.adrsrc = 1'b1;
            S_MEMWB: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTER: begin
                c.alusrca = 2'b10;
                c.aluop   = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB:    c.regwrite = 1'b1;
            S_JAL: begin
                c.alusrca  = 2'b01;
                c.alusrcb  = 2'b10;
                c.pcupdate = 1'b1;
            end
            S_BEQ: begin
                c.alusrca = 2'b10;
                c.aluop   = ALUOP_SUB;
                c.branch  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: ALUOp plus instruction fields -> 3-bit ALUControl.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  aluop_e     aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    // Select the ALU operation; op5 distinguishes R-type sub from I-type addi.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (op5 && funct7b5) alucontrol = ALU_SUB;
                        else                 alucontrol = ALU_ADD;
                    end
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V control FSM; control word registered alongside the state.
// Optional RISCV_MC_BNE_EN: BEQ state also takes bne (funct3=001) on ~Z.
module riscv_mc_controller
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Z,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    state_e state;
    state_e next_state;
    ctrl_t  ctrl;
    logic   taken;
    logic   op_ok;

    assign op_ok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                   (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BRANCH);

    // Next-state selection.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                if ((op == OP_LW) || (op == OP_SW)) next_state = S_MEMADR;
                else if (op == OP_RTYPE)            next_state = S_EXECUTER;
                else if (op == OP_ITYPE)            next_state = S_EXECUTEI;
                else if (op == OP_JAL)              next_state = S_JAL;
                else if (op == OP_BRANCH)           next_state = S_BEQ;
                else                                next_state = S_FETCH;
            end
            S_MEMADR: begin
                if (op == OP_SW) next_state = S_MEMWRITE;
                else             next_state = S_MEMREAD;
            end
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_JAL:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // State register; the control word is decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            ctrl  <= state_ctrl(S_FETCH);
        end else begin
            state <= next_state;
            ctrl  <= state_ctrl(next_state);
        end
    end

    // Branch condition evaluated from the live ALU zero flag.
    always_comb begin
        taken = 1'b0;
`ifdef RISCV_MC_BNE_EN
        case (funct3)
            3'b000:  taken = Z;
            3'b001:  taken = ~Z;
            default: taken = 1'b0;
        endcase
`else
        if (funct3 == 3'b000) taken = Z;
        else                  taken = 1'b0;
`endif
    end

    // Immediate format from the opcode.
    always_comb begin
        ImmSrc = IMM_I;
        case (op)
            OP_SW:     ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            default:   ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (ctrl.aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (ALUControl)
    );

    // Write enables are suppressed for as long as reset is held.
    assign PCWrite   = ~reset & (ctrl.pcupdate | (ctrl.branch & taken));
    assign IRWrite   = ~reset & ctrl.irwrite;
    assign RegWrite  = ~reset & ctrl.regwrite;
    assign MemWrite  = ~reset & ctrl.memwrite;
    assign illegal   = ~reset & (state == S_DECODE) & ~op_ok;
    assign AdrSrc    = ctrl.adrsrc;
    assign ResultSrc = ctrl.resultsrc;
    assign ALUSrcA   = ctrl.alusrca;
    assign ALUSrcB   = ctrl.alusrcb;
    assign state_dbg = state;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Directed self-checking bench for riscv_mc_controller (build with RISCV_MC_BNE_EN to test bne).
module tb_riscv_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Z;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                           MW = 4'd5, XR = 4'd6, XI = 4'd7, AWB = 4'd8, BQ = 4'd9, JL = 4'd10;

    riscv_mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Z(Z),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        op = o; funct3 = f3; funct7b5 = f7; Z = z;
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [3:0] st, input logic pcw,
                          input logic regw, input logic memw);
        check({tag, "_state"}, {4'd0, state_dbg}, {4'd0, st});
        check({tag, "_pcw"},   {7'd0, PCWrite},   {7'd0, pcw});
        check({tag, "_regw"},  {7'd0, RegWrite},  {7'd0, regw});
        check({tag, "_memw"},  {7'd0, MemWrite},  {7'd0, memw});
    endtask

    // Checks FETCH, steps into DECODE and then into the first execute state.
    task automatic fetch_decode(input string tag, input logic [1:0] imm, input logic [3:0] nxt);
        chk_st({tag, "_f"}, F, 1'b1, 1'b0, 1'b0);
        check({tag, "_f_irw"}, {7'd0, IRWrite}, 8'd1);
        cyc();
        chk_st({tag, "_d"}, D, 1'b0, 1'b0, 1'b0);
        check({tag, "_d_imm"}, {6'd0, ImmSrc}, {6'd0, imm});
        check({tag, "_d_ill"}, {7'd0, illegal}, 8'd0);
        cyc();
        check({tag, "_x_state"}, {4'd0, state_dbg}, {4'd0, nxt});
    endtask

    task automatic rtype(input string tag, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [2:0] ctl, input logic [3:0] xs,
                         input logic [1:0] srcb);
        set_in(o, f3, f7, 1'b0);
        fetch_decode(tag, 2'b00, xs);
        check({tag, "_x_ctl"},  {5'd0, ALUControl}, {5'd0, ctl});
        check({tag, "_x_srcb"}, {6'd0, ALUSrcB},    {6'd0, srcb});
        check({tag, "_x_regw"}, {7'd0, RegWrite},   8'd0);
        cyc();
        chk_st({tag, "_wb"}, AWB, 1'b0, 1'b1, 1'b0);
        cyc();
    endtask

    task automatic branch(input string tag, input logic [2:0] f3, input logic z, input logic pcw);
        set_in(7'b1100011, f3, 1'b0, z);
        fetch_decode(tag, 2'b10, BQ);
        chk_st({tag, "_b"}, BQ, pcw, 1'b0, 1'b0);
        check({tag, "_b_ctl"}, {5'd0, ALUControl}, 8'd1);
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        // Reset held for two edges
        cyc();
        chk_st("rst1", F, 1'b0, 1'b0, 1'b0);
        check("rst1_irw",  {7'd0, IRWrite}, 8'd0);
        check("rst1_ill",  {7'd0, illegal}, 8'd0);
        check("rst1_srcb", {6'd0, ALUSrcB}, 8'd2);
        cyc();
        chk_st("rst2", F, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("rel_pcw", {7'd0, PCWrite}, 8'd1);
        check("rel_irw", {7'd0, IRWrite}, 8'd1);
        check("rel_res", {6'd0, ResultSrc}, 8'd2);

        // lw: 5 cycles
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        fetch_decode("lw", 2'b00, MA);
        chk_st("lw_ma", MA, 1'b0, 1'b0, 1'b0);
        check("lw_ma_srca", {6'd0, ALUSrcA}, 8'd2);
        cyc();
        chk_st("lw_mr", MR, 1'b0, 1'b0, 1'b0);
        check("lw_mr_adr", {7'd0, AdrSrc}, 8'd1);
        check("lw_mr_res", {6'd0, ResultSrc}, 8'd0);
        cyc();
        chk_st("lw_wb", MWB, 1'b0, 1'b1, 1'b0);
        check("lw_wb_res", {6'd0, ResultSrc}, 8'd1);
        cyc();

        // sw: 4 cycles
        set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
        fetch_decode("sw", 2'b01, MA);
        cyc();
        chk_st("sw_mw", MW, 1'b0, 1'b0, 1'b1);
        check("sw_mw_adr", {7'd0, AdrSrc}, 8'd1);
        cyc();

        rtype("sub",  7'b0110011, 3'b000, 1'b1, 3'b001, XR, 2'b00);
        rtype("add",  7'b0110011, 3'b000, 1'b0, 3'b000, XR, 2'b00);
        rtype("and",  7'b0110011, 3'b111, 1'b0, 3'b010, XR, 2'b00);
        rtype("or",   7'b0110011, 3'b110, 1'b0, 3'b011, XR, 2'b00);
        rtype("slti", 7'b0010011, 3'b010, 1'b0, 3'b101, XI, 2'b01);
        rtype("addi", 7'b0010011, 3'b000, 1'b1, 3'b000, XI, 2'b01);
        rtype("xor",  7'b0110011, 3'b100, 1'b0, 3'b000, XR, 2'b00);

        // jal: 4 cycles
        set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
        fetch_decode("jal", 2'b11, JL);
        chk_st("jal_j", JL, 1'b1, 1'b0, 1'b0);
        check("jal_srca", {6'd0, ALUSrcA}, 8'd1);
        check("jal_srcb", {6'd0, ALUSrcB}, 8'd2);
        cyc();
        chk_st("jal_wb", AWB, 1'b0, 1'b1, 1'b0);
        cyc();

        branch("beq_t", 3'b000, 1'b1, 1'b1);
        branch("beq_n", 3'b000, 1'b0, 1'b0);
`ifdef RISCV_MC_BNE_EN
        branch("bne_t", 3'b001, 1'b0, 1'b1);
`else
        branch("bne_t", 3'b001, 1'b0, 1'b0);
`endif
        branch("bne_n", 3'b001, 1'b1, 1'b0);
        branch("blt",   3'b100, 1'b1, 1'b0);

        // Illegal opcode: 2 cycles, no writes
        set_in(7'b1111111, 3'b000, 1'b0, 1'b0);
        chk_st("ill_f", F, 1'b1, 1'b0, 1'b0);
        cyc();
        chk_st("ill_d", D, 1'b0, 1'b0, 1'b0);
        check("ill_d_ill", {7'd0, illegal}, 8'd1);
        cyc();
        chk_st("ill_nf", F, 1'b1, 1'b0, 1'b0);
        check("ill_nf_ill", {7'd0, illegal}, 8'd0);

        // Reset asserted in MEMWB suppresses the writeback and returns to FETCH
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        cyc(); cyc(); cyc(); cyc();
        check("mid_state", {4'd0, state_dbg}, {4'd0, MWB});
        reset = 1'b1;
        #1;
        check("mid_regw", {7'd0, RegWrite}, 8'd0);
        cyc();
        chk_st("mid_rst", F, 1'b0, 1'b0, 1'b0);
        check("mid_irw", {7'd0, IRWrite}, 8'd0);
        reset = 1'b0;
        #1;
        check("mid_rel_irw", {7'd0, IRWrite}, 8'd1);
        cyc();
        check("mid_rel_d", {4'd0, state_dbg}, {4'd0, D});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
